dvsd_cmp_tracker: RTL and testbench

- Downstream consumer of the 4-bit magnitude comparator `dvsd_cmp`.
- Accepts operand pairs together with the comparator's three result flags over a valid/ready handshake.
- Accumulates per-window statistics: count of each outcome, largest A operand, and a sticky flag-integrity error.
- Presents a report over a second valid/ready handshake, giving the comparator a sequential, self-checking sink.

---
 rtl/dvsd_cmp_tracker.sv | 155 +++++++++++++++
 tb/tb_dvsd_cmp_tracker.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/dvsd_cmp_tracker.sv
// Windowed statistics sink for the dvsd_cmp magnitude comparator.
// Define CMP_SELFCHECK_EN to add cmp_mismatch, a sticky per-window recheck of the comparator flags.
module dvsd_cmp_tracker #(
  parameter int WINDOW = 4,
  parameter int CNT_W  = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       A_in,
  input  logic [3:0]       B_in,
  input  logic             less_than,
  input  logic             equal_to,
  input  logic             greater_than,
  output logic             busy,
  output logic             rpt_valid,
  input  logic             rpt_ready,
  output logic [CNT_W-1:0] lt_count,
  output logic [CNT_W-1:0] eq_count,
  output logic [CNT_W-1:0] gt_count,
  output logic [3:0]       max_a,
  output logic             flag_err
`ifdef CMP_SELFCHECK_EN
  ,
  output logic             cmp_mismatch
`endif
);

  localparam int SW = $clog2(WINDOW + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, REPORT} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] lt_q, lt_d, eq_q, eq_d, gt_q, gt_d;
  logic [3:0]       max_q, max_d;
  logic             err_q, err_d;
  logic [SW-1:0]    smp_q, smp_d;
  logic             mis_q, mis_d;
  logic             clr;
  logic             one_hot;
  logic             mismatch;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  assign one_hot = ({less_than, equal_to, greater_than} == 3'b100) ||
                   ({less_than, equal_to, greater_than} == 3'b010) ||
                   ({less_than, equal_to, greater_than} == 3'b001);

`ifdef CMP_SELFCHECK_EN
  assign mismatch = {(A_in < B_in), (A_in == B_in), (A_in > B_in)} !=
                    {less_than, equal_to, greater_than};
`else
  logic unused_b;
  assign unused_b = ^B_in;
  assign mismatch = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    lt_d    = lt_q;
    eq_d    = eq_q;
    gt_d    = gt_q;
    max_d   = max_q;
    err_d   = err_q;
    smp_d   = smp_q;
    mis_d   = mis_q;
    clr     = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          state_d = ACCUM;
          clr     = 1'b1;
        end
      end
      ACCUM: begin
        if (in_valid) begin
          if (one_hot) begin
            if (less_than)    lt_d = sat_inc(lt_q);
            if (equal_to)     eq_d = sat_inc(eq_q);
            if (greater_than) gt_d = sat_inc(gt_q);
          end else begin
            err_d = 1'b1;
          end
          if (mismatch) mis_d = 1'b1;
          if (A_in > max_q) max_d = A_in;
          smp_d = smp_q + SW'(1);
          if (smp_q == SW'(WINDOW - 1)) state_d = REPORT;
        end
      end
      REPORT: begin
        // Handshake with start chains straight into the next window.
        if (rpt_ready) begin
          if (start) begin
            state_d = ACCUM;
            clr     = 1'b1;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
    if (clr) begin
      lt_d  = '0;
      eq_d  = '0;
      gt_d  = '0;
      max_d = '0;
      err_d = 1'b0;
      smp_d = '0;
      mis_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      lt_q    <= '0;
      eq_q    <= '0;
      gt_q    <= '0;
      max_q   <= '0;
      err_q   <= 1'b0;
      smp_q   <= '0;
      mis_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      lt_q    <= lt_d;
      eq_q    <= eq_d;
      gt_q    <= gt_d;
      max_q   <= max_d;
      err_q   <= err_d;
      smp_q   <= smp_d;
      mis_q   <= mis_d;
    end
  end

  assign in_ready  = (state_q == ACCUM);
  assign busy      = (state_q != IDLE);
  assign rpt_valid = (state_q == REPORT);
  assign lt_count  = lt_q;
  assign eq_count  = eq_q;
  assign gt_count  = gt_q;
  assign max_a     = max_q;
  assign flag_err  = err_q;
`ifdef CMP_SELFCHECK_EN
  assign cmp_mismatch = mis_q;
`else
  logic unused_mis;
  assign unused_mis = mis_q;
`endif

endmodule

// File: tb/tb_dvsd_cmp_tracker.sv
// Scoreboarded directed bench for dvsd_cmp_tracker: one default instance and one small
// saturating instance (CNT_W=2, WINDOW=6) sharing stimulus.
module tb_dvsd_cmp_tracker;
  localparam int W1 = 4, C1 = 8, W2 = 6, C2 = 2;

  logic clk = 1'b0;
  logic rst_n, start, in_valid, rpt_ready;
  logic [3:0] A_in, B_in;
  logic lt_f, eq_f, gt_f;

  logic in_ready_a, busy_a, rpt_valid_a, flag_err_a;
  logic [C1-1:0] lt_a, eq_a, gt_a;
  logic [3:0] max_a_a;
  logic in_ready_b, busy_b, rpt_valid_b, flag_err_b;
  logic [C2-1:0] lt_b, eq_b, gt_b;
  logic [3:0] max_a_b;
`ifdef CMP_SELFCHECK_EN
  logic mis_a, mis_b;
`endif

  dvsd_cmp_tracker #(.WINDOW(W1), .CNT_W(C1)) u_dut (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_a),
    .A_in(A_in), .B_in(B_in), .less_than(lt_f), .equal_to(eq_f), .greater_than(gt_f),
    .busy(busy_a), .rpt_valid(rpt_valid_a), .rpt_ready(rpt_ready),
    .lt_count(lt_a), .eq_count(eq_a), .gt_count(gt_a), .max_a(max_a_a), .flag_err(flag_err_a)
`ifdef CMP_SELFCHECK_EN
    , .cmp_mismatch(mis_a)
`endif
  );

  dvsd_cmp_tracker #(.WINDOW(W2), .CNT_W(C2)) u_sat (
    .clk(clk), .rst_n(rst_n), .start(start), .in_valid(in_valid), .in_ready(in_ready_b),
    .A_in(A_in), .B_in(B_in), .less_than(lt_f), .equal_to(eq_f), .greater_than(gt_f),
    .busy(busy_b), .rpt_valid(rpt_valid_b), .rpt_ready(rpt_ready),
    .lt_count(lt_b), .eq_count(eq_b), .gt_count(gt_b), .max_a(max_a_b), .flag_err(flag_err_b)
`ifdef CMP_SELFCHECK_EN
    , .cmp_mismatch(mis_b)
`endif
  );

  always #5 clk = ~clk;

  typedef struct {
    int lt;
    int eq;
    int gt;
    int mx;
    int err;
  } rpt_t;

  rpt_t exp_q[$];
  int m_lt, m_eq, m_gt, m_mx, m_err, m_n;
  int n_chk = 0, n_pass = 0, n_fail = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_chk++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  task automatic model_clear();
    m_lt = 0; m_eq = 0; m_gt = 0; m_mx = 0; m_err = 0; m_n = 0;
  endtask

  // Drive one sample, wait for acceptance, and update the reference model.
  task automatic send(input int sel, input logic [3:0] a, input logic [3:0] b,
                      input logic l, input logic e, input logic g);
    int win, cmax;
    bit got;
    rpt_t r;
    win = (sel != 0) ? W2 : W1;
    cmax = (sel != 0) ? 3 : 255;
    A_in = a; B_in = b; lt_f = l; eq_f = e; gt_f = g; in_valid = 1'b1;
    got = 1'b0;
    for (int i = 0; i < 20 && !got; i++) begin
      got = (sel != 0) ? in_ready_b : in_ready_a;
      step();
    end
    if (!got) check("send_timeout", 32'd0, 32'd1);
    else begin
      if ((int'(l) + int'(e) + int'(g)) == 1) begin
        if (l && m_lt < cmax) m_lt++;
        if (e && m_eq < cmax) m_eq++;
        if (g && m_gt < cmax) m_gt++;
      end else m_err = 1;
      if (int'(a) > m_mx) m_mx = int'(a);
      m_n++;
      if (m_n == win) begin
        r.lt = m_lt; r.eq = m_eq; r.gt = m_gt; r.mx = m_mx; r.err = m_err;
        exp_q.push_back(r);
        model_clear();
      end
    end
  endtask

  // Wait for a report, compare it with the scoreboard head, then handshake it.
  task automatic get_report(input int sel, input logic st);
    bit rv;
    rpt_t e;
    rv = 1'b0;
    for (int i = 0; i < 20 && !rv; i++) begin
      rv = (sel != 0) ? rpt_valid_b : rpt_valid_a;
      if (!rv) step();
    end
    if (!rv) check("rpt_timeout", 32'd0, 32'd1);
    else if (exp_q.size() == 0) check("rpt_unexpected", 32'd1, 32'd0);
    else begin
      e = exp_q.pop_front();
      check("rpt_lt",  (sel != 0) ? 32'(lt_b)       : 32'(lt_a),       e.lt);
      check("rpt_eq",  (sel != 0) ? 32'(eq_b)       : 32'(eq_a),       e.eq);
      check("rpt_gt",  (sel != 0) ? 32'(gt_b)       : 32'(gt_a),       e.gt);
      check("rpt_max", (sel != 0) ? 32'(max_a_b)    : 32'(max_a_a),    e.mx);
      check("rpt_err", (sel != 0) ? 32'(flag_err_b) : 32'(flag_err_a), e.err);
      rpt_ready = 1'b1; start = st;
      step();
      rpt_ready = 1'b0; start = 1'b0;
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b1; in_valid = 1'b1; rpt_ready = 1'b0;
    A_in = 4'd0; B_in = 4'd0; lt_f = 1'b0; eq_f = 1'b0; gt_f = 1'b0;
    model_clear();

    // Reset with start and in_valid held high
    repeat (3) step();
    check("rst_in_ready", in_ready_a, 1'b0);
    check("rst_busy", busy_a, 1'b0);
    check("rst_rpt_valid", rpt_valid_a, 1'b0);
    check("rst_counts", {lt_a, eq_a, gt_a}, 0);
    check("rst_max", max_a_a, 4'd0);
    check("rst_flag_err", flag_err_a, 1'b0);
    check("rst_busy_sat", busy_b, 1'b0);
    rst_n = 1'b1; start = 1'b0; in_valid = 1'b0;
    step();
    check("idle_in_ready", in_ready_a, 1'b0);

    // Basic window
    start = 1'b1; step(); start = 1'b0;
    check("accum_busy", busy_a, 1'b1);
    check("accum_in_ready", in_ready_a, 1'b1);
    send(0, 4'b1000, 4'b1001, 1, 0, 0);
    check("cnt_after_1", lt_a, 8'd1);
    send(0, 4'b0010, 4'b1110, 1, 0, 0);
    send(0, 4'b1010, 4'b1010, 0, 1, 0);
    send(0, 4'b0111, 4'b0110, 0, 0, 1);
    check("rpt_rise", rpt_valid_a, 1'b1);

    // Report backpressure, then back-to-back window
    check("sb_depth", exp_q.size(), 1);
    for (int i = 0; i < 5; i++) begin
      in_valid = i[0];
      step();
      check("bp_lt", lt_a, exp_q[0].lt);
      check("bp_max", max_a_a, exp_q[0].mx);
      check("bp_in_ready", in_ready_a, 1'b0);
      check("bp_rpt_valid", rpt_valid_a, 1'b1);
    end
    in_valid = 1'b0;
    get_report(0, 1'b1);
    check("b2b_in_ready", in_ready_a, 1'b1);
    check("b2b_counts", {lt_a, eq_a, gt_a}, 0);
    check("b2b_max", max_a_a, 4'd0);

    // Bad flags in the second window
    send(0, 4'd5, 4'd9, 1, 0, 1);
    check("bad_err_now", flag_err_a, 1'b1);
    send(0, 4'd9, 4'd9, 0, 1, 0);
    send(0, 4'd12, 4'd12, 0, 1, 0);
    send(0, 4'd3, 4'd3, 0, 1, 0);
    check("bad_rpt_rise", rpt_valid_a, 1'b1);
    in_valid = 1'b0;
    get_report(0, 1'b0);
    check("bad_idle", busy_a, 1'b0);

    // Saturation on the CNT_W=2, WINDOW=6 instance
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    model_clear(); exp_q.delete();
    start = 1'b1; step(); start = 1'b0;
    for (int i = 0; i < 6; i++) send(1, 4'b1111, 4'b1111, 0, 1, 0);
    check("sat_rpt_rise", rpt_valid_b, 1'b1);
    in_valid = 1'b0;
`ifdef CMP_SELFCHECK_EN
    check("sat_no_mismatch", mis_b, 1'b0);
`endif
    get_report(1, 1'b0);

    // Mid-window reset, then self-check sample
    rst_n = 1'b0; step(); rst_n = 1'b1; step();
    model_clear(); exp_q.delete();
    start = 1'b1; step(); start = 1'b0;
    send(0, 4'd6, 4'd2, 0, 0, 1);
    send(0, 4'd1, 4'd2, 1, 0, 0);
    check("pre_rst_busy", busy_a, 1'b1);
    rst_n = 1'b0;
    #1;
    check("midrst_busy", busy_a, 1'b0);
    check("midrst_in_ready", in_ready_a, 1'b0);
    check("midrst_counts", {lt_a, eq_a, gt_a}, 0);
    check("midrst_max", max_a_a, 4'd0);
    in_valid = 1'b0;
    step();
    rst_n = 1'b1;
    model_clear();
    step();
    check("postrst_idle", busy_a, 1'b0);
    start = 1'b1; step(); start = 1'b0;
    send(0, 4'b0011, 4'b1101, 0, 0, 1);
    check("selfchk_gt", gt_a, 8'd1);
    check("selfchk_err", flag_err_a, 1'b0);
`ifdef CMP_SELFCHECK_EN
    check("selfchk_mismatch", mis_a, 1'b1);
`endif
    in_valid = 1'b0;
    step();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
